// File: rtl/grade_tracker_pkg.sv
// Shared sizing, increment constants and types for the grade tracker.
package grade_tracker_pkg;
    localparam int unsigned SLOTS     = 8;
    localparam int unsigned GW        = 8;
    localparam int unsigned MAX_GRADE = 100;
    localparam int unsigned INC_SMALL = 1;
    localparam int unsigned INC_MID   = 5;
    localparam int unsigned INC_LARGE = 25;
    localparam int unsigned PW        = $clog2(SLOTS);
    localparam int unsigned CW        = $clog2(SLOTS + 1);

    typedef logic [GW-1:0] grade_t;
    typedef logic [GW:0]   wide_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
endpackage

// File: rtl/grade_tracker_if.sv
// Front-panel buttons in, display bus out.
interface grade_tracker_if;
    import grade_tracker_pkg::*;

    logic   Increment1;
    logic   Increment5;
    logic   Increment25;
    logic   saveGrade;
    logic   setGrade;
    logic   resetGrades;
    logic   clearCurrent;
    logic   displayGrades;
    grade_t allGrades;

    modport master (
        output Increment1, Increment5, Increment25, saveGrade, setGrade,
               resetGrades, clearCurrent, displayGrades,
        input  allGrades
    );

    modport slave (
        input  Increment1, Increment5, Increment25, saveGrade, setGrade,
               resetGrades, clearCurrent, displayGrades,
        output allGrades
    );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, with rise/fall pulses
// derived from the synchronized level.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~prev_q;
    assign fall_o  = ~s2_q & prev_q;
endmodule

// File: rtl/grade_tracker.sv
// Builds a current grade from increment buttons, stores up to SLOTS grades
// and lets the display browse them.
module grade_tracker
    import grade_tracker_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    grade_tracker_if.slave bus
);
    localparam int unsigned NBTN = 8;
    localparam int unsigned BI1 = 0, BI5 = 1, BI25 = 2, BSAVE = 3, BSET = 4, BRST = 5,
                            BCLR = 6, BDISP = 7;

    logic [NBTN-1:0] raw, level, rise, fall;

    assign raw = {bus.displayGrades, bus.clearCurrent, bus.resetGrades, bus.setGrade,
                  bus.saveGrade, bus.Increment25, bus.Increment5, bus.Increment1};

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .btn_i   (raw[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    logic unused_edges;
    assign unused_edges = ^{level[NBTN-2:0], fall[NBTN-2:0], rise[BDISP]};

    grade_t cur_q, cur_d;
    cnt_t   count_q, count_d;
    ptr_t   ptr_q, ptr_d;
    grade_t store_q [SLOTS];
    grade_t store_d [SLOTS];
    grade_t inc;
    wide_t  sum_w;

    always_comb begin
        cur_d   = cur_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        store_d = store_q;

        inc = '0;
        if (rise[BI1])  inc = inc + grade_t'(INC_SMALL);
        if (rise[BI5])  inc = inc + grade_t'(INC_MID);
        if (rise[BI25]) inc = inc + grade_t'(INC_LARGE);
        // One extra bit so the saturation compare never sees a wrapped value.
        sum_w = wide_t'(cur_q) + wide_t'(inc);

        if (rise[BRST]) begin
            cur_d   = '0;
            count_d = '0;
            for (int i = 0; i < SLOTS; i++) store_d[i] = '0;
        end else if (rise[BCLR]) begin
            cur_d = '0;
        end else if (rise[BSAVE]) begin
            if (count_q < cnt_t'(SLOTS)) begin
                store_d[count_q[PW-1:0]] = cur_q;
                count_d = count_q + cnt_t'(1);
                cur_d   = '0;
            end
        end else if (rise[BSET]) begin
            if (cnt_t'(ptr_q) < count_q) store_d[ptr_q] = cur_q;
        end else if (rise[BI1] | rise[BI5] | rise[BI25]) begin
            cur_d = (sum_w > wide_t'(MAX_GRADE)) ? grade_t'(MAX_GRADE) : sum_w[GW-1:0];
        end

        if (rise[BRST]) begin
            ptr_d = '0;
        end else if (fall[BDISP]) begin
            if (count_q == '0) begin
                ptr_d = '0;
            end else if (cnt_t'(ptr_q) + cnt_t'(1) >= count_q) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < SLOTS; i++) store_q[i] <= '0;
        end else begin
            cur_q   <= cur_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        bus.allGrades = cur_q;
        if (level[BDISP]) bus.allGrades = (count_q != '0) ? store_q[ptr_q] : '0;
    end
endmodule

// File: tb/tb_grade_tracker.sv
// Directed bench for grade_tracker; expected values are hand-computed.
module tb_grade_tracker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    grade_tracker_if bus ();

    grade_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (bus.allGrades === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, bus.allGrades, exp);
        end
    endtask

    // Bits: 0 Inc1, 1 Inc5, 2 Inc25, 3 save, 4 set, 5 resetGrades, 6 clear, 7 display.
    task automatic drive(input logic [7:0] b);
        bus.Increment1    = b[0];
        bus.Increment5    = b[1];
        bus.Increment25   = b[2];
        bus.saveGrade     = b[3];
        bus.setGrade      = b[4];
        bus.resetGrades   = b[5];
        bus.clearCurrent  = b[6];
        bus.displayGrades = b[7];
    endtask

    task automatic press(input logic [7:0] b);
        drive(b);
        tick(1);
        drive(8'h00);
        tick(3);
    endtask

    task automatic disp_on();
        bus.displayGrades = 1'b1;
        tick(3);
    endtask

    task automatic disp_off();
        bus.displayGrades = 1'b0;
        tick(3);
    endtask

    initial begin
        drive(8'h00);
        tick(2);
        check("reset_state", 8'd0);
        rst_n = 1'b1;
        tick(2);
        check("after_reset_release", 8'd0);

        // Held Increment5 acts once; Increment1 pressed while it is held.
        drive(8'h02);
        tick(3);
        check("inc5", 8'd5);
        drive(8'h03);
        tick(6);
        check("inc1_while_inc5_held", 8'd6);
        drive(8'h00);
        tick(3);
        check("release_no_action", 8'd6);
        press(8'h04);
        check("inc25_first", 8'd31);
        press(8'h04);
        check("inc25_second", 8'd56);

        // Latency: sampled at edge N, visible after edge N+2.
        drive(8'h01);
        @(posedge clk);
        #1 drive(8'h00);
        @(posedge clk);
        #1 check("latency_n_plus_1", 8'd56);
        @(posedge clk);
        #1 check("latency_n_plus_2", 8'd57);
        tick(2);
        press(8'h40);
        check("clear_current", 8'd0);
        press(8'h04);
        press(8'h04);
        press(8'h02);
        press(8'h01);
        check("rebuild_56", 8'd56);

        press(8'h08);
        check("save_clears_cur", 8'd0);
        disp_on();
        check("display_entry0", 8'd56);
        disp_off();
        check("display_off_shows_cur", 8'd0);
        disp_on();
        check("ptr_wrap_single", 8'd56);
        disp_off();

        // Simultaneous increments, then saturation.
        press(8'h07);
        check("inc_sum_31", 8'd31);
        press(8'h04);
        press(8'h04);
        press(8'h04);
        check("cur_saturates", 8'd100);
        press(8'h04);
        press(8'h04);
        press(8'h02);
        press(8'h01);
        check("cur_stays_100", 8'd100);
        press(8'h08);
        check("save_second", 8'd0);
        disp_on();
        check("browse_0", 8'd56);
        disp_off();
        disp_on();
        check("browse_1", 8'd100);
        disp_off();
        disp_on();
        check("browse_wrap", 8'd56);
        disp_off();

        // Fill the store with 1..9; the ninth save must be dropped.
        press(8'h20);
        check("reset_grades", 8'd0);
        for (int g = 1; g <= 9; g++) begin
            for (int k = 0; k < g; k++) press(8'h01);
            press(8'h08);
        end
        check("ninth_save_ignored", 8'd9);
        for (int e = 0; e < 8; e++) begin
            disp_on();
            check($sformatf("browse_full_%0d", e), 8'(e + 1));
            disp_off();
        end
        disp_on();
        check("browse_full_wrap", 8'd1);
        disp_off();

        // ptr now 1; overwrite entry 1 with 25.
        press(8'h40);
        press(8'h04);
        press(8'h10);
        check("set_keeps_cur", 8'd25);
        disp_on();
        check("set_entry1", 8'd25);
        disp_off();
        disp_on();
        check("entry2_untouched", 8'd3);
        disp_off();

        // clearCurrent beats saveGrade: cur zeroed, nothing appended.
        press(8'h48);
        check("clear_beats_save", 8'd0);

        // resetGrades beats saveGrade in the same cycle.
        press(8'h04);
        press(8'h28);
        check("reset_beats_save_cur", 8'd0);
        disp_on();
        check("store_empty", 8'd0);
        disp_off();
        press(8'h02);
        press(8'h08);
        disp_on();
        check("store_restarted", 8'd5);
        disp_off();

        // Asynchronous reset in the middle of an increment.
        press(8'h04);
        check("pre_async_reset", 8'd25);
        drive(8'h02);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_immediate", 8'd0);
        drive(8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("inflight_discarded", 8'd0);
        disp_on();
        check("store_cleared_by_rst", 8'd0);
        disp_off();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
